// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: shares a single-port 2bpp frame buffer between scanline prefetch and two writers.
// Define FB_STATS_EN to enable the saturating underflow counter on dbg_uflow_cnt.
module frame_buffer_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned LINE_LEN   = 224,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LOW_WM     = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] line_base,
  input  logic              pix_pop,
  output logic [1:0]        pix_out,
  output logic              pix_uflow,
  output logic              line_busy,
  input  logic              wr0_req,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [1:0]        wr0_data,
  output logic              wr0_gnt,
  input  logic              wr1_req,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [1:0]        wr1_data,
  output logic              wr1_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [1:0]        mem_wdata,
  input  logic [1:0]        mem_rdata,
  output logic [15:0]       dbg_uflow_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned IDX_W = $clog2(LINE_LEN + 1);

  typedef enum logic {IDLE, FETCH} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WR0, OP_WR1} op_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              rd_p1;
  logic              rd_p2;
  logic              rr_wr1;

  logic [OCC_W-1:0]  occ_c;
  op_t               op_c;
  logic              elig0_c;
  logic              elig1_c;
  logic              push_c;
  logic              pop_c;
  logic              pop_ok_c;

  // One memory op per cycle; reads still in the address/data pipeline count toward occupancy.
  always_comb begin
    occ_c   = OCC_W'(count) + OCC_W'(rd_p1) + OCC_W'(rd_p2);
    elig0_c = wr0_req & ~wr0_gnt;
    elig1_c = wr1_req & ~wr1_gnt;
    op_c    = OP_NONE;
    if (!line_start) begin
      if (state == FETCH && occ_c < OCC_W'(LOW_WM)) begin
        op_c = OP_READ;
      end else if (elig0_c || elig1_c) begin
        op_c = (elig0_c && (!elig1_c || !rr_wr1)) ? OP_WR0 : OP_WR1;
      end else if (state == FETCH && occ_c < OCC_W'(FIFO_DEPTH)) begin
        op_c = OP_READ;
      end
    end
  end

  assign push_c   = rd_p2 & ~line_start;
  assign pop_c    = pix_pop & ~line_start;
  assign pop_ok_c = pop_c & (count != '0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      base_q    <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      rd_p1     <= 1'b0;
      rd_p2     <= 1'b0;
      rr_wr1    <= 1'b0;
      pix_out   <= '0;
      pix_uflow <= 1'b0;
      line_busy <= 1'b0;
      wr0_gnt   <= 1'b0;
      wr1_gnt   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      rd_p1   <= (op_c == OP_READ);
      rd_p2   <= rd_p1 & ~line_start;
      mem_we  <= (op_c == OP_WR0) || (op_c == OP_WR1);
      wr0_gnt <= (op_c == OP_WR0);
      wr1_gnt <= (op_c == OP_WR1);
      case (op_c)
        OP_READ: begin
          mem_addr <= base_q + ADDR_W'(idx);
          idx      <= idx + IDX_W'(1);
          if (idx == IDX_W'(LINE_LEN - 1)) begin
            state     <= IDLE;
            line_busy <= 1'b0;
          end
        end
        OP_WR0: begin
          mem_addr  <= wr0_addr;
          mem_wdata <= wr0_data;
          rr_wr1    <= 1'b1;
        end
        OP_WR1: begin
          mem_addr  <= wr1_addr;
          mem_wdata <= wr1_data;
          rr_wr1    <= 1'b0;
        end
        default: ;
      endcase
      if (line_start) begin
        state     <= FETCH;
        line_busy <= 1'b1;
        idx       <= '0;
        base_q    <= line_base;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        count     <= '0;
        pix_out   <= '0;
        pix_uflow <= 1'b0;
      end else begin
        if (pop_c) begin
          if (pop_ok_c) begin
            pix_out <= fifo_mem[rd_ptr];
            rd_ptr  <= rd_ptr + PTR_W'(1);
          end else begin
            pix_out   <= '0;
            pix_uflow <= 1'b1;
          end
        end
        if (push_c) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        case ({push_c, pop_ok_c})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Pixel storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge Clk) begin
    if (push_c) begin
      fifo_mem[wr_ptr] <= mem_rdata;
    end
  end

`ifdef FB_STATS_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dbg_uflow_cnt <= '0;
    end else if (pop_c && !pop_ok_c && dbg_uflow_cnt != 16'hFFFF) begin
      dbg_uflow_cnt <= dbg_uflow_cnt + 16'd1;
    end
  end
`else
  assign dbg_uflow_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Bench for frame_buffer_arbiter: queue-level reference model compared every cycle, plus directed literal checks.
module tb_frame_buffer_arbiter;

  localparam int unsigned LINE_LEN   = 224;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned LOW_WM     = 2;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [15:0] line_base = '0;
  logic        pix_pop = 1'b0;
  logic [1:0]  pix_out;
  logic        pix_uflow;
  logic        line_busy;
  logic        wr0_req = 1'b0;
  logic [15:0] wr0_addr = '0;
  logic [1:0]  wr0_data = '0;
  logic        wr0_gnt;
  logic        wr1_req = 1'b0;
  logic [15:0] wr1_addr = '0;
  logic [1:0]  wr1_data = '0;
  logic        wr1_gnt;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [1:0]  mem_wdata;
  logic [1:0]  mem_rdata = '0;
  logic [15:0] dbg_uflow_cnt;

  frame_buffer_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n), .line_start(line_start), .line_base(line_base),
    .pix_pop(pix_pop), .pix_out(pix_out), .pix_uflow(pix_uflow), .line_busy(line_busy),
    .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
    .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_uflow_cnt(dbg_uflow_cnt)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit tb_on    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] pat(input logic [15:0] a);
    return 2'(a[1:0] + a[9:8] + a[3:2]);
  endfunction

  // Frame buffer: synchronous write, read data one cycle after the address.
  logic [1:0] fb [65536];
  initial for (int i = 0; i < 65536; i++) fb[i] = pat(16'(i));
  always @(posedge Clk) begin
    if (mem_we) fb[mem_addr] <= mem_wdata;
    mem_rdata <= fb[mem_addr];
  end

  // Reference model: FIFO and in-flight reads as queues, driven by the arbitration rules.
  typedef struct { logic [1:0] d; int unsigned due; } rd_t;
  logic [1:0]  m_fifo [$];
  rd_t         m_infl [$];
  rd_t         m_tmp;
  int unsigned cyc;
  bit          m_fetch, m_rr, m_e0, m_e1;
  int          m_idx, m_occ, m_op, m_reads;
  logic [15:0] m_base, m_a, m_last;
  logic [1:0]  exp_pix = '0;
  bit          exp_uflow = 1'b0, exp_busy = 1'b0, exp_we = 1'b0, exp_g0 = 1'b0, exp_g1 = 1'b0;
  logic [15:0] exp_addr = '0, exp_dbg = '0;
  logic [1:0]  exp_wd = '0;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_fifo.delete(); m_infl.delete();
      cyc = 0; m_fetch = 0; m_rr = 0; m_idx = 0; m_reads = 0; m_base = '0; m_last = '0;
      exp_pix = '0; exp_uflow = 0; exp_busy = 0; exp_we = 0; exp_g0 = 0; exp_g1 = 0;
      exp_addr = '0; exp_dbg = '0; exp_wd = '0;
    end else begin
      if (line_start) begin
        m_fifo.delete(); m_infl.delete();
        exp_pix = '0; exp_uflow = 0; m_fetch = 1; m_idx = 0; m_reads = 0; m_base = line_base;
        exp_we = 0; exp_g0 = 0; exp_g1 = 0;
      end else begin
        m_occ = m_fifo.size() + m_infl.size();
        m_e0 = wr0_req && !exp_g0;
        m_e1 = wr1_req && !exp_g1;
        m_op = 0;
        if (m_fetch && m_occ < int'(LOW_WM)) m_op = 1;
        else if (m_e0 || m_e1) m_op = (m_e0 && (!m_e1 || !m_rr)) ? 2 : 3;
        else if (m_fetch && m_occ < int'(FIFO_DEPTH)) m_op = 1;
        if (pix_pop) begin
          if (m_fifo.size() == 0) begin
            exp_pix = '0; exp_uflow = 1;
`ifdef FB_STATS_EN
            if (exp_dbg != 16'hFFFF) exp_dbg = exp_dbg + 16'd1;
`endif
          end else begin
            exp_pix = m_fifo.pop_front();
          end
        end
        if (m_infl.size() > 0 && m_infl[0].due == cyc) begin
          m_fifo.push_back(m_infl[0].d);
          void'(m_infl.pop_front());
        end
        exp_we = 0; exp_g0 = 0; exp_g1 = 0;
        case (m_op)
          1: begin
            m_a = m_base + 16'(m_idx);
            exp_addr = m_a;
            m_tmp.d = fb[m_a];
            m_tmp.due = cyc + 2;
            m_infl.push_back(m_tmp);
            m_idx++; m_reads++; m_last = m_a;
            if (m_idx == int'(LINE_LEN)) m_fetch = 0;
          end
          2: begin exp_addr = wr0_addr; exp_wd = wr0_data; exp_we = 1; exp_g0 = 1; m_rr = 1; end
          3: begin exp_addr = wr1_addr; exp_wd = wr1_data; exp_we = 1; exp_g1 = 1; m_rr = 0; end
          default: ;
        endcase
      end
      exp_busy = m_fetch;
      cyc++;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge Clk) begin
    if (tb_on) begin
      check("pix_out", 32'(pix_out), 32'(exp_pix));
      check("pix_uflow", 32'(pix_uflow), 32'(exp_uflow));
      check("line_busy", 32'(line_busy), 32'(exp_busy));
      check("mem_we", 32'(mem_we), 32'(exp_we));
      check("mem_addr", 32'(mem_addr), 32'(exp_addr));
      check("wr0_gnt", 32'(wr0_gnt), 32'(exp_g0));
      check("wr1_gnt", 32'(wr1_gnt), 32'(exp_g1));
      check("dbg_uflow_cnt", 32'(dbg_uflow_cnt), 32'(exp_dbg));
      if (exp_we) check("mem_wdata", 32'(mem_wdata), 32'(exp_wd));
    end
  end

  task automatic start_line(input logic [15:0] base);
    line_base = base;
    line_start = 1'b1;
    @(negedge Clk);
    line_start = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_cnt3;
    repeat (2) @(negedge Clk);
    check("rst_pix_out", 32'(pix_out), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_line_busy", 32'(line_busy), 32'd0);
    check("rst_uflow", 32'(pix_uflow), 32'd0);
    check("rst_dbg", 32'(dbg_uflow_cnt), 32'd0);
    Reset_n = 1'b1;
    tb_on = 1'b1;

    // Three pops on an empty FIFO.
    @(negedge Clk);
    pix_pop = 1'b1;
    repeat (3) @(negedge Clk);
    pix_pop = 1'b0;
`ifdef FB_STATS_EN
    exp_cnt3 = 16'd3;
`else
    exp_cnt3 = 16'd0;
`endif
    check("uflow3_pix", 32'(pix_out), 32'd0);
    check("uflow3_flag", 32'(pix_uflow), 32'd1);
    check("uflow3_cnt", 32'(dbg_uflow_cnt), 32'(exp_cnt3));

    // Full line at 0x0100 with steady pops from cycle 4.
    start_line(16'h0100);
    @(negedge Clk);
    check("first_rd_addr", 32'(mem_addr), 32'h0100);
    check("first_rd_we", 32'(mem_we), 32'd0);
    check("line_uflow_clr", 32'(pix_uflow), 32'd0);
    check("line_busy_on", 32'(line_busy), 32'd1);
    @(negedge Clk);
    @(negedge Clk);
    pix_pop = 1'b1;
    repeat (LINE_LEN) @(negedge Clk);
    pix_pop = 1'b0;
    check("steady_uflow", 32'(pix_uflow), 32'd0);
    check("steady_last_pix", 32'(pix_out), 32'd3);
    check("steady_busy_off", 32'(line_busy), 32'd0);
    check("model_reads", 32'(m_reads), 32'd224);
    check("model_last_addr", 32'(m_last), 32'h01DF);

    // Both writers with a full FIFO alternate grants, starting with wr0.
    start_line(16'h0300);
    repeat (20) @(negedge Clk);
    wr0_addr = 16'h8000; wr0_data = 2'd1; wr1_addr = 16'h9000; wr1_data = 2'd2;
    wr0_req = 1'b1; wr1_req = 1'b1;
    @(negedge Clk);
    check("rr1_g0", 32'(wr0_gnt), 32'd1);
    check("rr1_g1", 32'(wr1_gnt), 32'd0);
    check("rr1_we", 32'(mem_we), 32'd1);
    check("rr1_addr", 32'(mem_addr), 32'h8000);
    @(negedge Clk);
    check("rr2_g0", 32'(wr0_gnt), 32'd0);
    check("rr2_g1", 32'(wr1_gnt), 32'd1);
    check("rr2_addr", 32'(mem_addr), 32'h9000);
    check("rr2_wdata", 32'(mem_wdata), 32'd2);
    @(negedge Clk);
    check("rr3_g0", 32'(wr0_gnt), 32'd1);
    check("rr3_g1", 32'(wr1_gnt), 32'd0);
    wr0_req = 1'b0; wr1_req = 1'b0;

    // Address wrap at the top of the frame buffer.
    start_line(16'hFFFE);
    @(negedge Clk);
    check("wrap0", 32'(mem_addr), 32'hFFFE);
    @(negedge Clk);
    check("wrap1", 32'(mem_addr), 32'hFFFF);
    @(negedge Clk);
    check("wrap2", 32'(mem_addr), 32'h0000);
    @(negedge Clk);
    check("wrap3", 32'(mem_addr), 32'h0001);

    // Restart mid-line with reads in flight; stale pixels must not surface.
    start_line(16'h0100);
    @(negedge Clk);
    start_line(16'h0200);
    repeat (3) @(negedge Clk);
    pix_pop = 1'b1;
    @(negedge Clk);
    pix_pop = 1'b0;
    check("restart_first_pix", 32'(pix_out), 32'd2);
    check("restart_uflow", 32'(pix_uflow), 32'd0);
    pix_pop = 1'b1;
    repeat (3) @(negedge Clk);
    pix_pop = 1'b0;
    check("restart_4th_pix", 32'(pix_out), 32'(pat(16'h0203)));

    // Asynchronous reset mid-fetch with a full FIFO.
    start_line(16'h0100);
    repeat (20) @(negedge Clk);
    check("pre_rst_busy", 32'(line_busy), 32'd1);
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(line_busy), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_pix", 32'(pix_out), 32'd0);
    check("arst_we", 32'(mem_we), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    pix_pop = 1'b1;
    @(negedge Clk);
    pix_pop = 1'b0;
    check("post_rst_empty_uflow", 32'(pix_uflow), 32'd1);
    check("post_rst_empty_pix", 32'(pix_out), 32'd0);
    @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
